param_proc: RTL

- Parametrised successor to the team's single-cycle toy processor.
- Multi-cycle fetch/decode/execute core with an NREGS-entry register file, a separate synchronous instruction port, and a req/ack data-memory handshake that tolerates wait states.
- Halts by a status output instead of ending simulation; flags illegal opcodes instead of printing.
- Sits between an instruction ROM and a data RAM/peripheral bus in the test SoC.

---
 rtl/param_proc.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/param_proc.sv
// rtl/param_proc.sv - multi-cycle parametrised fetch/decode/execute core with wait-state data port
module param_proc #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 8,
    parameter int NREGS    = 4
) (
    input  logic                clk,
    input  logic                nrst,
    output logic [ADDRSIZE-1:0] iaddr,
    input  logic [31:0]         idata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    input  logic                mem_ack,
    output logic [5:0]          flags,
    output logic                halted,
    output logic                illegal
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_BRA = 4'd1;
    localparam logic [3:0] OP_NOP = 4'd2;
    localparam logic [3:0] OP_STR = 4'd3;
    localparam logic [3:0] OP_SHF = 4'd4;
    localparam logic [3:0] OP_CPL = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LDR = 4'd8;
    localparam logic [3:0] OP_LDI = 4'd9;

    logic [2:0]          state;
    logic [ADDRSIZE-1:0] pc;
    logic [31:0]         ir;
    logic [WIDTH-1:0]    regs [NREGS];

    logic [3:0]          opcode, ccode, rd, rs;
    logic                im;
    logic [15:0]         imm;
    logic [ADDRSIZE-1:0] addr;

    assign opcode = ir[31:28];
    assign ccode  = ir[27:24];
    assign im     = ir[27];
    assign rd     = ir[23:20];
    assign rs     = ir[19:16];
    assign imm    = ir[15:0];
    assign addr   = ADDRSIZE'(imm);
    assign iaddr  = pc;

    // Indices beyond the register file read as zero and never write.
    logic [WIDTH-1:0] rd_val, rs_val;
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        if (32'(rd) < NREGS) rd_val = regs[rd[RW-1:0]];
        if (32'(rs) < NREGS) rs_val = regs[rs[RW-1:0]];
    end

    logic [WIDTH-1:0]   opnd, alu_res;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [5:0]         shamt;
    logic               alu_carry, alu_op;
    always_comb begin
        opnd      = im ? WIDTH'(imm) : rs_val;
        sum       = {1'b0, rd_val} + {1'b0, opnd};
        prod      = {{WIDTH{1'b0}}, rd_val} * {{WIDTH{1'b0}}, rs_val};
        shamt     = imm[5:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_op    = 1'b1;
        case (opcode)
            OP_SHF: if (32'(shamt) < WIDTH) alu_res = im ? (rd_val << shamt) : (rd_val >> shamt);
            OP_CPL: alu_res = ~opnd;
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_MUL: begin
                alu_res   = prod[WIDTH-1:0];
                alu_carry = |prod[2*WIDTH-1:WIDTH];
            end
            default: alu_op = 1'b0;
        endcase
    end

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_res;
        if (state == S_EXEC) begin
            if (opcode == OP_LDI) begin
                wr_en   = 1'b1;
                wr_data = WIDTH'(imm);
            end else if (alu_op) begin
                wr_en = 1'b1;
            end
        end else if (state == S_MEM && mem_ack && !mem_we) begin
            wr_en   = 1'b1;
            wr_data = mem_rdata;
        end
        if (32'(rd) >= NREGS) wr_en = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rd[RW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            flags     <= 6'b000001;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= idata;
                    pc    <= pc + ADDRSIZE'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        // The taken branch lands after the DECODE increment and overrides it.
                        OP_BRA: if (ccode < 4'd6 && flags[ccode[2:0]]) pc <= addr;
                        OP_NOP, OP_LDI: ;
                        OP_STR, OP_LDR: begin
                            mem_req   <= 1'b1;
                            mem_we    <= (opcode == OP_STR);
                            mem_addr  <= addr;
                            mem_wdata <= rd_val;
                            state     <= S_MEM;
                        end
                        default: begin
                            if (alu_op)
                                flags <= {alu_res[WIDTH-1], alu_res == '0, ^alu_res,
                                          ~alu_res[0], alu_carry, 1'b1};
                            else
                                illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule
